// File: rtl/lsu_mem_master_if.sv
// Bus bundles for the load/store initiator.
//
// lsu_core_if : execute-stage request channel and one-cycle response pulse.
//   master modport = core (drives req_*, receives resp_*)
//   slave  modport = LSU  (receives req_*, drives req_ready and resp_*)
//
// lsu_ram_if  : word-wide synchronous RAM port with a 1-cycle registered read.
//   master modport = LSU  (drives mem_addr/mem_din/mem_we, receives mem_dout)
//   slave  modport = RAM
interface lsu_core_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

interface lsu_ram_if #(
    parameter int addr_width = 12
);
    logic [addr_width-1:0] mem_addr;
    logic [31:0]           mem_din;
    logic                  mem_we;
    logic [31:0]           mem_dout;

    modport master (
        output mem_addr, mem_din, mem_we,
        input  mem_dout
    );

    modport slave (
        input  mem_addr, mem_din, mem_we,
        output mem_dout
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the core execute stage and a word-wide
// synchronous data RAM without byte enables. One byte-addressed RV32 load or
// store is handled at a time; sub-word stores are done as read-modify-write.
//
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous, active-high reset
//   core : lsu_core_if.slave - request (valid/ready, store, funct3, addr,
//          wdata) and registered response (valid pulse, err, rdata)
//   ram  : lsu_ram_if.master - registered mem_addr/mem_din/mem_we, mem_dout
//          valid one cycle after mem_addr is sampled
module lsu_mem_master #(
    parameter int addr_width = 12
) (
    input  logic      clk,
    input  logic      rst,
    lsu_core_if.slave core,
    lsu_ram_if.master ram
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_DATA,
        WR,
        RESP
    } state_e;

    state_e state_q, state_d;

    // Latched request fields
    logic                  store_q,  store_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            off_q,    off_d;
    logic [31:0]           wdata_q,  wdata_d;

    // Registered outputs
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q,   resp_err_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic [addr_width-1:0] mem_addr_q,   mem_addr_d;
    logic [31:0]           mem_din_q,    mem_din_d;
    logic                  mem_we_q,     mem_we_d;

    // Address bits above the RAM index wrap away by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^core.req_addr[31:addr_width+2];

    // ------------------------------------------------------------------
    // Request decode (valid only while IDLE with req_valid)
    // ------------------------------------------------------------------
    logic accept;
    logic funct3_legal;
    logic misaligned;
    logic req_err;
    logic req_sw;

    assign accept = core.req_valid && (state_q == IDLE);

    always_comb begin
        if (core.req_store) begin
            funct3_legal = core.req_funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            funct3_legal = core.req_funct3 inside {3'b000, 3'b001, 3'b010,
                                                   3'b100, 3'b101};
        end
        misaligned = ((core.req_funct3[1:0] == 2'b01) && core.req_addr[0]) ||
                     ((core.req_funct3[1:0] == 2'b10) && (core.req_addr[1:0] != 2'b00));
        req_err    = !funct3_legal || misaligned;
        req_sw     = core.req_store && (core.req_funct3 == 3'b010);
    end

    // ------------------------------------------------------------------
    // Lane datapath on the registered RAM read word
    // ------------------------------------------------------------------
    logic [4:0]  lane_sh;
    logic [31:0] lane_word;
    logic [31:0] load_data;
    logic [31:0] lane_mask;
    logic [31:0] merged_word;

    assign lane_sh   = {off_q, 3'b000};
    assign lane_word = ram.mem_dout >> lane_sh;

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{24{lane_word[7]}},  lane_word[7:0]};
            3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b100:  load_data = {24'h0, lane_word[7:0]};
            3'b101:  load_data = {16'h0, lane_word[15:0]};
            default: load_data = lane_word;
        endcase
    end

    // Only SB/SH reach the merge path; the other lanes pass through untouched.
    assign lane_mask   = ((funct3_q[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
    assign merged_word = (ram.mem_dout & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_we_q     <= mem_we_d;
        end
    end

    // NOTE: the captured request fields carry no reset; they are only read in
    // states reachable after an accept edge has overwritten them.
    always_ff @(posedge clk) begin
        store_q  <= store_d;
        funct3_q <= funct3_d;
        off_q    <= off_d;
        wdata_q  <= wdata_d;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)     state_d = RESP;
                    else if (req_sw) state_d = WR;
                    else             state_d = RD;
                end
            end
            RD:      state_d = RD_DATA;
            RD_DATA: state_d = store_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned (no latch); mem_we defaults low so it can only pulse.
    always_comb begin
        store_d      = store_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_we_d     = 1'b0;
        resp_valid_d = (state_d == RESP);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    store_d      = core.req_store;
                    funct3_d     = core.req_funct3;
                    off_d        = core.req_addr[1:0];
                    wdata_d      = core.req_wdata;
                    resp_err_d   = req_err;
                    resp_rdata_d = '0;
                    if (!req_err) begin
                        mem_addr_d = core.req_addr[addr_width+1:2];
                        if (req_sw) begin
                            mem_din_d = core.req_wdata;
                            mem_we_d  = 1'b1;
                        end
                    end
                end
            end
            RD_DATA: begin
                if (store_q) begin
                    mem_din_d = merged_word;
                    mem_we_d  = 1'b1;
                end else begin
                    resp_rdata_d = load_data;
                end
            end
            WR: begin
                resp_rdata_d = '0;
            end
            default: ;
        endcase
    end

    assign core.req_ready  = (state_q == IDLE);
    assign core.resp_valid = resp_valid_q;
    assign core.resp_err   = resp_err_q;
    assign core.resp_rdata = resp_rdata_q;
    assign ram.mem_addr    = mem_addr_q;
    assign ram.mem_din     = mem_din_q;
    assign ram.mem_we      = mem_we_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed cases plus randomized
// traffic against a byte-array reference model, with a scoreboard queue
// filled at accept time and drained by an independent response monitor.
module tb_lsu_mem_master;

    localparam int AW     = 12;
    localparam int WORDS  = 1 << AW;
    localparam int BYTES  = WORDS * 4;

    logic clk;
    logic rst;

    lsu_core_if          core_if ();
    lsu_ram_if #(.addr_width(AW)) ram_if ();

    lsu_mem_master #(.addr_width(AW)) dut (
        .clk  (clk),
        .rst  (rst),
        .core (core_if),
        .ram  (ram_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM, 1-cycle registered read.
    logic [31:0] ram [WORDS];
    always @(posedge clk) begin
        if (ram_if.mem_we) ram[ram_if.mem_addr] <= ram_if.mem_din;
        ram_if.mem_dout <= ram[ram_if.mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Scoreboard and reference model
    // ------------------------------------------------------------------
    typedef struct {
        bit        err;
        bit [31:0] rdata;
        int        lat;
        int        we;
        bit [31:0] widx;
        bit [31:0] wword;
        int        acc;
    } exp_t;

    exp_t      exp_q [$];
    bit [7:0]  mb [BYTES];
    int        tests_n   = 0;
    int        fails_n   = 0;
    int        accepts_n = 0;
    int        resps_n   = 0;
    int        aborts_n  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_n++;
        if (act !== exp) begin
            fails_n++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit [31:0] model_word(input int unsigned idx);
        bit [31:0] w = 0;
        for (int k = 0; k < 4; k++) w |= 32'(mb[idx*4 + k]) << (8*k);
        return w;
    endfunction

    // Reference behaviour: sizes in bytes, memory as a flat wrapping byte array.
    function automatic exp_t model(input bit st, input bit [2:0] f3,
                                   input bit [31:0] a, input bit [31:0] wd);
        exp_t        e;
        int          n     = 1 << f3[1:0];
        bit          legal = st ? (f3 inside {3'd0, 3'd1, 3'd2})
                                : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        bit          mis   = (a & 32'(n - 1)) != 0;
        int unsigned ba    = a % BYTES;
        bit [31:0]   v     = 0;
        e.err = !legal || mis;
        e.rdata = 0; e.we = 0; e.widx = 0; e.wword = 0; e.acc = 0;
        if (e.err) begin
            e.lat = 1;
        end else if (st) begin
            for (int i = 0; i < n; i++) mb[ba + i] = 8'(wd >> (8*i));
            e.lat   = (n == 4) ? 2 : 4;
            e.we    = 1;
            e.widx  = ba / 4;
            e.wword = model_word(ba / 4);
        end else begin
            for (int i = 0; i < n; i++) v |= 32'(mb[ba + i]) << (8*i);
            if (!f3[2] && n < 4 && v[8*n - 1]) v |= ~((32'd1 << (8*n)) - 1);
            e.rdata = v;
            e.lat   = 3;
        end
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic issue(input bit st, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit hold, input bit track);
        bit   rdy;
        int   n = 0;
        exp_t e;
        core_if.req_valid  = 1'b1;
        core_if.req_store  = st;
        core_if.req_funct3 = f3;
        core_if.req_addr   = a;
        core_if.req_wdata  = wd;
        do begin
            @(negedge clk);
            rdy = core_if.req_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 50);
        #1;
        if (!rdy) begin
            check("accept_timeout", core_if.req_ready, 1'b1);
            core_if.req_valid = 1'b0;
        end else begin
            accepts_n++;
            if (track) begin
                e     = model(st, f3, a, wd);
                e.acc = cyc;
                exp_q.push_back(e);
            end
            if (!hold) core_if.req_valid = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        int        we_cnt    = 0;
        bit [31:0] last_addr = 0;
        bit [31:0] last_din  = 0;
        exp_t      e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("req_ready", core_if.req_ready,
                      32'(accepts_n == resps_n + aborts_n));
                if (ram_if.mem_we) begin
                    we_cnt++;
                    last_addr = 32'(ram_if.mem_addr);
                    last_din  = ram_if.mem_din;
                end
                if (core_if.resp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", core_if.resp_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_err",   core_if.resp_err,   e.err);
                        check("resp_rdata", core_if.resp_rdata, e.rdata);
                        check("latency",    cyc - e.acc + 1,    e.lat);
                        check("we_cycles",  we_cnt,             e.we);
                        if (e.we != 0) begin
                            check("wr_addr", last_addr, e.widx);
                            check("wr_data", last_din,  e.wword);
                        end
                    end
                    we_cnt = 0;
                    resps_n++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit [31:0] v;
        bit [2:0]  f3;
        bit [31:0] a;
        bit        st;
        bit        hold;
        int        n;

        core_if.req_valid  = 1'b0;
        core_if.req_store  = 1'b0;
        core_if.req_funct3 = 3'b000;
        core_if.req_addr   = '0;
        core_if.req_wdata  = '0;
        for (int i = 0; i < WORDS; i++) begin
            v = $urandom;
            ram[i] <= v;
            for (int k = 0; k < 4; k++) mb[i*4 + k] = 8'(v >> (8*k));
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",  core_if.req_ready,  1'b1);
        check("rst_resp_valid", core_if.resp_valid, 1'b0);
        check("rst_resp_err",   core_if.resp_err,   1'b0);
        check("rst_resp_rdata", core_if.resp_rdata, 32'h0);
        check("rst_mem_addr",   32'(ram_if.mem_addr), 32'h0);
        check("rst_mem_din",    ram_if.mem_din,     32'h0);
        check("rst_mem_we",     ram_if.mem_we,      1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed: store then every load flavour on the same word.
        issue(1, 3'b010, 32'h10, 32'h8899AABB, 0, 1);
        issue(0, 3'b000, 32'h11, 0, 0, 1);
        issue(0, 3'b100, 32'h11, 0, 0, 1);
        issue(0, 3'b001, 32'h12, 0, 0, 1);
        issue(0, 3'b101, 32'h12, 0, 0, 1);
        issue(0, 3'b010, 32'h10, 0, 0, 1);
        // Read-modify-write sub-word stores.
        issue(1, 3'b000, 32'h13, 32'h12345655, 0, 1);
        issue(0, 3'b010, 32'h10, 0, 0, 1);
        issue(1, 3'b001, 32'h10, 32'h0000C0DE, 0, 1);
        issue(0, 3'b010, 32'h10, 0, 0, 1);
        // Errors.
        issue(0, 3'b010, 32'h12, 0, 0, 1);
        issue(0, 3'b001, 32'h13, 0, 0, 1);
        issue(1, 3'b001, 32'h01, 32'hFFFF, 0, 1);
        issue(0, 3'b011, 32'h10, 0, 0, 1);
        issue(1, 3'b100, 32'h10, 32'h1, 0, 1);
        // Address wrap.
        issue(0, 3'b010, 32'h4010, 0, 0, 1);
        // Back-to-back with req_valid held high.
        for (int i = 0; i < 6; i++) issue(0, 3'b010, 32'(i*4), 0, (i != 5), 1);

        // Reset in the RD_DATA cycle of an SB: no write may happen.
        issue(1, 3'b000, 32'h10, 32'h000000EE, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        aborts_n++;
        @(negedge clk);
        check("abort_resp_valid", core_if.resp_valid, 1'b0);
        check("abort_mem_we",     ram_if.mem_we,      1'b0);
        check("abort_req_ready",  core_if.req_ready,  1'b1);
        @(posedge clk);
        #1;
        issue(0, 3'b010, 32'h10, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) begin
                f3 = st ? 3'($urandom_range(0, 2))
                        : ((3'($urandom_range(0, 4)) == 3'd3) ? 3'd5 : 3'($urandom_range(0, 4)));
                if (!st && f3 == 3'd3) f3 = 3'd4;
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_C03F;
            if ($urandom_range(0, 1) != 0) a = a & ~(32'((1 << f3[1:0]) - 1));
            hold = (i != 399) && ($urandom_range(0, 1) != 0);
            issue(st, f3, a, $urandom, hold, 1);
            if (!hold) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end

        n = 0;
        while ((resps_n + aborts_n != accepts_n) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", resps_n + aborts_n, accepts_n);
        check("queue_empty", exp_q.size(), 0);
        for (int i = 0; i < WORDS; i++) check("ram_final", ram[i], model_word(i));

        $display("[TB] %0d tests run, %0d failed", tests_n, fails_n);
        $finish;
    end

endmodule
